// File: rtl/countdown6bit_timer.sv
// countdown6bit_timer: 6-bit loadable down-counter with a one-shot terminal
// pulse, a reload register and a three-state sequencing FSM.
//
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to make the counter restart
// from the reload register after each terminal event instead of parking in
// DONE. With the macro undefined the counter is one-shot.
//
// CLRDEL / CLKDEL are kept so existing instantiations still elaborate. Register
// updates here are zero-delay, so they only need to be non-negative.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | out of clear, waiting for the first load; enable ignored
//  RUN     | counting down on enabled edges; busy = 1
//  DONE    | terminal count reached (or zero loaded); waiting for a load
module countdown6bit_timer #(
    parameter int CLRDEL = 10,
    parameter int CLKDEL = 15
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       load,
    input  logic [5:0] load_value,
    input  logic       enable,
    output logic [5:0] count,
    output logic       zero,
    output logic       done,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if ((CLRDEL < 0) || (CLKDEL < 0)) begin : g_bad_delay
        $error("countdown6bit_timer: delay parameters must be non-negative");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [5:0] count_nxt;
    logic [5:0] reload;
    logic [5:0] reload_nxt;
    logic       done_nxt;

    // Next-state, next-count and terminal-pulse decode; load beats enable in every state.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;
        if (load) begin
            reload_nxt = load_value;
            count_nxt  = load_value;
            if (load_value != 6'd0) begin
                state_nxt = ST_RUN;
            end else begin
                // A zero load is its own terminal event.
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (enable) begin
                        if (count > 6'd1) begin
                            count_nxt = count - 6'd1;
                        end else if (count == 6'd1) begin
                            count_nxt = 6'd0;
                            done_nxt  = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            state_nxt = ST_RUN;
`else
                            state_nxt = ST_DONE;
`endif
                        end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            // Count sits at 0 for one enabled cycle, then restarts,
                            // giving a period of reload+1 edges.
                            count_nxt = reload;
`else
                            // Unreachable in one-shot mode: RUN is never entered at 0.
                            count_nxt = count;
`endif
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    count_nxt = count;
                end
                default: begin
                    // Recover from the unused encoding without a spurious pulse.
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, reload and done registers; clear wins asynchronously.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= ST_IDLE;
            count  <= 6'd0;
            reload <= 6'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            done   <= done_nxt;
        end
    end

    // Status flags decoded straight from the registers.
    always_comb begin
        zero = (count == 6'd0);
        busy = (state == ST_RUN);
    end

endmodule

// File: doc/countdown6bit_timer.md
COUNTDOWN6BIT_TIMER -- requirements
Module: countdown6bit_timer

Interface
REQ-001 SHALL have parameter CLRDEL, default 10, assignment delay (ns) applied to register updates caused by clear.
REQ-002 SHALL have parameter CLKDEL, default 15, assignment delay (ns) applied to register updates caused by clock.
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port clear  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  load request, sampled on rising clock.
REQ-006 SHALL have port load_value  input  6  unsigned start value captured on load.
REQ-007 SHALL have port enable  input  1  decrement qualifier, sampled on rising clock.
REQ-008 SHALL have port count  output  6  current registered count.
REQ-009 SHALL have port zero  output  1  high whenever count equals 0.
REQ-010 SHALL have port done  output  1  registered one-clock terminal-count pulse.
REQ-011 SHALL have port busy  output  1  high while in state RUN.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE; busy = (state == RUN).
REQ-013 SHALL hold a 6-bit reload register, written with load_value on every accepted load.
REQ-014 load SHALL take priority over enable in every state: count <= load_value; state <= RUN if load_value != 0, else DONE.
REQ-015 Load of 0 SHALL assert done for the following clock cycle.
REQ-016 In RUN with enable=1 and count > 1, count SHALL decrement by exactly 1 per clock.
REQ-017 In RUN with enable=1 and count == 1, count SHALL become 0, state DONE, and done SHALL be high for exactly the next cycle.
REQ-018 In RUN with enable=0, count and state SHALL hold and busy SHALL remain 1.
REQ-019 In IDLE and DONE, enable SHALL have no effect and count SHALL hold.
REQ-020 done SHALL be low in every cycle not covered by REQ-015/REQ-017 and SHALL never be high two consecutive cycles, except through back-to-back terminal events.
REQ-021 Count SHALL never wrap below 0; arithmetic SHALL be 6-bit unsigned with maximum load 63.
REQ-022 zero SHALL be derived combinationally from count.
REQ-023 Load arriving in the same cycle as a terminal count SHALL win: no done pulse; new value loaded.

Reset
REQ-024 clear SHALL act asynchronously and take priority over all inputs.
REQ-025 While clear is high: count = 0, reload register = 0, state = IDLE, done = 0, busy = 0, zero = 1.
REQ-026 Clear asserted mid-RUN SHALL abort the countdown with no done pulse.
REQ-027 After clear deasserts, the block SHALL remain in IDLE until a load is accepted.

Configuration
REQ-028 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL select reload behaviour.
REQ-029 With macro defined: on the terminal event of REQ-017, count SHALL load the reload register and state SHALL remain RUN (busy stays 1); done still pulses one cycle; the reload register is never 0 in this path, since loads of 0 go to DONE.
REQ-030 With macro undefined: REQ-017 behaviour applies unchanged (one-shot), and the block SHALL wait in DONE.

Verification
REQ-031 clear pulse mid-count at count=17 -> count=0, busy=0, done=0, zero=1 immediately, with no clock edge required.
REQ-032 load=1, load_value=5, enable held 1 -> count 5,4,3,2,1,0; done high only in the cycle after count reaches 0; busy falls with state DONE.
REQ-033 load_value=63, enable toggled 1/0 every cycle -> count decrements only on enabled edges; 63 enabled edges reach 0.
REQ-034 load_value=0 -> state DONE, count=0, one done pulse, busy never asserted.
REQ-035 load_value=9 asserted on the same edge where count 1->0 would occur -> count=9, state RUN, no done pulse.
REQ-036 With COUNTDOWN_AUTO_RELOAD_EN, load_value=3, enable=1 -> count 3,2,1,0,3,2,1,0...; done pulses every 4 cycles; busy stays 1.
